// File: rtl/id_decode_queue_pkg.sv
// id_decode_queue_pkg: MIPS opcode fields plus the class/ALU/MDU encodings shared with EX and MDU.
package id_decode_queue_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03,
    OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07, OP_ADDI = 6'h08,
    OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
    OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_COP0 = 6'h10, OP_SPECIAL2 = 6'h1C, OP_LB = 6'h20,
    OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29,
    OP_SW = 6'h2B;
  localparam logic [5:0] TAIL_SLL = 6'h00, TAIL_SRL = 6'h02, TAIL_SRA = 6'h03, TAIL_SLLV = 6'h04,
    TAIL_SRLV = 6'h06, TAIL_SRAV = 6'h07, TAIL_JR = 6'h08, TAIL_JALR = 6'h09, TAIL_MOVZ = 6'h0A,
    TAIL_MOVN = 6'h0B, TAIL_SYSCALL = 6'h0C, TAIL_MFHI = 6'h10, TAIL_MTHI = 6'h11,
    TAIL_MFLO = 6'h12, TAIL_MTLO = 6'h13, TAIL_MULT = 6'h18, TAIL_MULTU = 6'h19, TAIL_DIV = 6'h1A,
    TAIL_DIVU = 6'h1B, TAIL_ADD = 6'h20, TAIL_ADDU = 6'h21, TAIL_SUB = 6'h22, TAIL_SUBU = 6'h23,
    TAIL_AND = 6'h24, TAIL_OR = 6'h25, TAIL_XOR = 6'h26, TAIL_NOR = 6'h27, TAIL_SLT = 6'h2A,
    TAIL_SLTU = 6'h2B, TAIL_MUL = 6'h02, TAIL_CLZ = 6'h20, TAIL_CLO = 6'h21, TAIL_TLBR = 6'h01,
    TAIL_TLBWI = 6'h02, TAIL_TLBWR = 6'h06, TAIL_TLBP = 6'h08, TAIL_ERET = 6'h18;
  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
  localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04;
  typedef enum logic [2:0] {
    CLASS_NOP, CLASS_ALU, CLASS_SHIFT, CLASS_MDU, CLASS_LOAD, CLASS_STORE, CLASS_BRANCH, CLASS_SYS
  } class_e;
  localparam logic [3:0] ALU_OP_ADD = 4'd0, ALU_OP_SUB = 4'd1, ALU_OP_CLZ = 4'd2, ALU_OP_CLO = 4'd3,
    ALU_OP_AND = 4'd4, ALU_OP_SLT = 4'd5, ALU_OP_OR = 4'd6, ALU_OP_SLTU = 4'd7, ALU_OP_NOR = 4'd8,
    ALU_OP_XOR = 4'd9, ALU_OP_LUI = 4'd10;
  localparam logic [3:0] MDU_OP_NONE = 4'd0, MDU_OP_DIV = 4'd1, MDU_OP_DIVU = 4'd2, MDU_OP_MUL = 4'd3,
    MDU_OP_MULT = 4'd4, MDU_OP_MULTU = 4'd5, MDU_OP_MFHI = 4'd6, MDU_OP_MFLO = 4'd7,
    MDU_OP_MTHI = 4'd8, MDU_OP_MTLO = 4'd9;
endpackage

// File: rtl/id_decode_fields.sv
// id_decode_fields: combinational decode of one instruction word into class/op/regwr/reserved fields.
module id_decode_fields
  import id_decode_queue_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [2:0]  cls_o,
  output logic [3:0]  alu_op_o,
  output logic [3:0]  mdu_op_o,
  output logic        regwr_o,
  output logic        rsvd_o
);
  logic [5:0] op, fn;
  logic [4:0] rs, rt;
  logic hit;
  assign op = instr_i[31:26];
  assign rs = instr_i[25:21];
  assign rt = instr_i[20:16];
  assign fn = instr_i[5:0];
  always_comb begin
    cls_o = CLASS_NOP;
    alu_op_o = ALU_OP_ADD;
    mdu_op_o = MDU_OP_NONE;
    regwr_o = 1'b0;
    hit = 1'b1;
    case (op)
      OP_SPECIAL: case (fn)
        TAIL_SLL, TAIL_SRL, TAIL_SRA, TAIL_SLLV, TAIL_SRLV, TAIL_SRAV: begin
          cls_o = CLASS_SHIFT;
          regwr_o = 1'b1;
        end
        TAIL_JR, TAIL_JALR: begin
          cls_o = CLASS_BRANCH;
          regwr_o = fn == TAIL_JALR;
        end
        TAIL_MOVZ, TAIL_MOVN: cls_o = CLASS_ALU;
        TAIL_SYSCALL: cls_o = CLASS_SYS;
        TAIL_MFHI, TAIL_MFLO, TAIL_MTHI, TAIL_MTLO, TAIL_MULT, TAIL_MULTU, TAIL_DIV, TAIL_DIVU: begin
          cls_o = CLASS_MDU;
          regwr_o = fn == TAIL_MFHI || fn == TAIL_MFLO;
          mdu_op_o = fn == TAIL_DIV ? MDU_OP_DIV : fn == TAIL_DIVU ? MDU_OP_DIVU :
                     fn == TAIL_MULT ? MDU_OP_MULT : fn == TAIL_MULTU ? MDU_OP_MULTU :
                     fn == TAIL_MFHI ? MDU_OP_MFHI : fn == TAIL_MFLO ? MDU_OP_MFLO :
                     fn == TAIL_MTHI ? MDU_OP_MTHI : MDU_OP_MTLO;
        end
        TAIL_ADD, TAIL_ADDU, TAIL_SUB, TAIL_SUBU, TAIL_AND, TAIL_OR, TAIL_XOR, TAIL_NOR, TAIL_SLT, TAIL_SLTU: begin
          cls_o = CLASS_ALU;
          regwr_o = 1'b1;
          alu_op_o = fn == TAIL_SUB || fn == TAIL_SUBU ? ALU_OP_SUB : fn == TAIL_AND ? ALU_OP_AND :
                     fn == TAIL_OR ? ALU_OP_OR : fn == TAIL_XOR ? ALU_OP_XOR :
                     fn == TAIL_NOR ? ALU_OP_NOR : fn == TAIL_SLT ? ALU_OP_SLT :
                     fn == TAIL_SLTU ? ALU_OP_SLTU : ALU_OP_ADD;
        end
        default: hit = 1'b0;
      endcase
      OP_REGIMM: case (rt)
        RT_BLTZ, RT_BGEZ: cls_o = CLASS_BRANCH;
        RT_BLTZAL, RT_BGEZAL: begin
          cls_o = CLASS_BRANCH;
          regwr_o = 1'b1;
        end
        default: hit = 1'b0;
      endcase
      OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls_o = CLASS_BRANCH;
      OP_JAL: begin
        cls_o = CLASS_BRANCH;
        regwr_o = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        cls_o = CLASS_ALU;
        regwr_o = 1'b1;
        alu_op_o = op == OP_SLTI ? ALU_OP_SLT : op == OP_SLTIU ? ALU_OP_SLTU : op == OP_ANDI ? ALU_OP_AND :
                   op == OP_ORI ? ALU_OP_OR : op == OP_XORI ? ALU_OP_XOR : op == OP_LUI ? ALU_OP_LUI : ALU_OP_ADD;
      end
      OP_COP0: begin
        cls_o = CLASS_SYS;
        regwr_o = !rs[4] && rs == RS_MFC0;
        hit = rs[4] ? fn inside {TAIL_TLBR, TAIL_TLBWI, TAIL_TLBWR, TAIL_TLBP, TAIL_ERET}
                    : rs == RS_MFC0 || rs == RS_MTC0;
      end
      OP_SPECIAL2: case (fn)
        TAIL_MUL: begin
          cls_o = CLASS_MDU;
          mdu_op_o = MDU_OP_MUL;
          regwr_o = 1'b1;
        end
        TAIL_CLZ, TAIL_CLO: begin
          cls_o = CLASS_ALU;
          alu_op_o = fn == TAIL_CLZ ? ALU_OP_CLZ : ALU_OP_CLO;
          regwr_o = 1'b1;
        end
        default: hit = 1'b0;
      endcase
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        cls_o = CLASS_LOAD;
        regwr_o = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: cls_o = CLASS_STORE;
      default: hit = 1'b0;
    endcase
    // The all-zero word is a NOP, and unrecognised words issue as class 0 with every field cleared.
    if (!hit || instr_i == '0) begin
      cls_o = CLASS_NOP;
      alu_op_o = ALU_OP_ADD;
      mdu_op_o = MDU_OP_NONE;
      regwr_o = 1'b0;
    end
    rsvd_o = !hit && instr_i != '0;
  end
endmodule

// File: rtl/id_decode_queue.sv
// id_decode_queue: DEPTH-entry fetch-to-issue queue whose head is decoded into registered control fields.
module id_decode_queue
  import id_decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  input  logic [AW-1:0] in_pc_i,
  input  logic [AW-1:0] in_instr_i,
  output logic          in_ready_o,
  input  logic          flush_i,
  input  logic          mdu_busy_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW-1:0] out_pc_o,
  output logic [AW-1:0] out_instr_o,
  output logic [2:0]    out_class_o,
  output logic [3:0]    out_alu_op_o,
  output logic [3:0]    out_mdu_op_o,
  output logic          out_regwr_o,
  output logic          out_rsvd_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] pc_mem [DEPTH];
  logic [AW-1:0] instr_mem [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic in_ready_q, push, pop, byp;
  logic [AW-1:0] pc_q, instr_q, nxt_pc, nxt_instr;
  logic [2:0] cls_q, nxt_cls;
  logic [3:0] alu_q, mdu_q, nxt_alu, nxt_mdu;
  logic regwr_q, rsvd_q, nxt_regwr, nxt_rsvd;
  assign out_valid_o = count_q != '0 && !(cls_q == CLASS_MDU && mdu_busy_i);
  always_comb begin
    push = in_valid_i && in_ready_q && !flush_i;
    pop = out_valid_o && out_ready_i && !flush_i;
    wr_d = flush_i ? '0 : !push ? wr_q : wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1);
    rd_d = flush_i ? '0 : !pop ? rd_q : rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1);
    count_d = flush_i ? '0 : count_q + CW'(push) - CW'(pop);
    // An entry landing in the slot that becomes the head bypasses storage so it shows one edge later.
    byp = push && wr_q == rd_d;
    nxt_pc = byp ? in_pc_i : pc_mem[rd_d];
    nxt_instr = byp ? in_instr_i : instr_mem[rd_d];
  end
  id_decode_fields u_fields (
    .instr_i (nxt_instr[31:0]),
    .cls_o   (nxt_cls),
    .alu_op_o(nxt_alu),
    .mdu_op_o(nxt_mdu),
    .regwr_o (nxt_regwr),
    .rsvd_o  (nxt_rsvd)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      in_ready_q <= 1'b0;
      pc_q <= '0;
      instr_q <= '0;
      cls_q <= '0;
      alu_q <= '0;
      mdu_q <= '0;
      regwr_q <= 1'b0;
      rsvd_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
      in_ready_q <= count_d < CW'(DEPTH);
      if (count_d != '0) begin
        pc_q <= nxt_pc;
        instr_q <= nxt_instr;
        cls_q <= nxt_cls;
        alu_q <= nxt_alu;
        mdu_q <= nxt_mdu;
        regwr_q <= nxt_regwr;
        rsvd_q <= nxt_rsvd;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q] <= in_pc_i;
      instr_mem[wr_q] <= in_instr_i;
    end
  end
  assign in_ready_o = in_ready_q;
  assign count_o = count_q;
  assign out_pc_o = pc_q;
  assign out_instr_o = instr_q;
  assign out_class_o = cls_q;
  assign out_alu_op_o = alu_q;
  assign out_mdu_op_o = mdu_q;
  assign out_regwr_o = regwr_q;
  assign out_rsvd_o = rsvd_q;
endmodule

// File: doc/id_decode_queue.md
Name: id_decode_queue

Overview:
- Parametrised successor to the combinational decode stage: a DEPTH-entry instruction queue between fetch and issue that buffers {pc, instr} pairs and decodes the head entry into registered-class control fields.
- Adds behaviour the plain decoder lacks:
  - valid/ready handshakes on both sides;
  - pipeline flush;
  - MDU-busy issue interlock;
  - reserved-instruction detection;
  - an occupancy counter for fetch throttling.

Parameters:
- DEPTH, 4, number of queue entries; any value 2..16, not required to be a power of two.
- AW, 32, PC and instruction width.
- CW, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active low.
- in_valid_i  in  1  fetch presents an entry.
- in_pc_i  in  AW  PC of the fetched instruction.
- in_instr_i  in  AW  fetched instruction word.
- in_ready_o  out  1  queue can accept this cycle.
- flush_i  in  1  discard all entries (mispredict, exception, ERET).
- mdu_busy_i  in  1  multiply/divide unit is still computing.
- out_valid_o  out  1  head entry is issuable.
- out_ready_i  in  1  issue stage consumes the head.
- out_pc_o  out  AW  head PC.
- out_instr_o  out  AW  head instruction.
- out_class_o  out  3  instruction class of the head.
- out_alu_op_o  out  4  ALU op code of the head.
- out_mdu_op_o  out  4  MDU op code of the head.
- out_regwr_o  out  1  head writes the GPR file (unconditional MOVN/MOVZ excluded).
- out_rsvd_o  out  1  head is a reserved/unrecognised encoding.
- count_o  out  CW  current occupancy.

Behaviour:
- Reset: when rst_n is low at a clk edge, these clear: rd_ptr, wr_ptr, count, out_valid_o, in_ready_o, and every out_* field. Storage array contents are don't-care. When reset is released, in_ready_o=1 and count_o=0. Reset mid-stream drops all entries.
- Push: occurs when in_valid_i && in_ready_o. The entry is written at wr_ptr, and wr_ptr wraps from DEPTH-1 to 0.
- Pop: occurs when out_valid_o && out_ready_i. rd_ptr advances and wraps from DEPTH-1 to 0.
- in_ready_o: equals (count < DEPTH), registered from next count. A full queue does not accept a push even if a pop happens in the same cycle.
- Count update:
  - push and no pop: count+1;
  - pop and no push: count-1;
  - both or neither: unchanged.
- Flush: flush_i has priority over push and pop in the same cycle. On flush, pointers and count clear next cycle, and the input in that cycle is dropped.
- Latency:
  - An entry pushed at edge N is visible on out_* after edge N, so out_valid_o can be high in cycle N+1.
  - Head decode is combinational from storage; out_* fields are registered from the next head.
- Interlock: out_valid_o = (count != 0) && !(out_class_o == MDU && mdu_busy_i). The mdu_busy_i term is combinational. Head fields stay stable while stalled.
- Decode encodings:
  - alu_op: SUB/SUBU=1, CLZ=2, CLO=3, AND/ANDI=4, SLT/SLTI=5, OR/ORI=6, SLTU/SLTIU=7, NOR=8, XOR/XORI=9, LUI=10, else 0.
  - mdu_op: DIV=1, DIVU=2, MUL=3, MULT=4, MULTU=5, MFHI=6, MFLO=7, MTHI=8, MTLO=9, else 0.
- Class encoding:
  - 0 NOP/other (instr==0 is class 0, rsvd=0);
  - 1 ALU (R or I arithmetic/logic);
  - 2 SHIFT;
  - 3 MDU;
  - 4 LOAD;
  - 5 STORE;
  - 6 BRANCH/JUMP (including link forms);
  - 7 CP0/SYSTEM (MTC0, MFC0, ERET, SYSCALL, TLBP/TLBR/TLBWI/TLBWR).
- Reserved instructions: out_rsvd_o=1 for any non-zero word matching none of the above. Such an entry is still issued with class 0; the exception is raised downstream.
- Empty: when empty, out_valid_o=0, and out_* hold their last values (don't-care).

Decomposition:
- Shared package: OP_*/TAIL_*/RT_*/RS_* opcode constants (existing CPUConstants), plus new CLASS_* (3-bit), ALU_OP_* and MDU_OP_* localparams so that the EX and MDU blocks share the same encodings.
- Sub-module id_decode_fields: purely combinational, instr in and class/alu_op/mdu_op/regwr/rsvd out. It is instantiated once, on the next-head word.
- Queue storage and control stay in id_decode_queue.

Test Plan:
- Reset, then push 4 entries on consecutive cycles (pc 0x100..0x10C, instr ADDU $3,$1,$2 = 0x00221821) with out_ready_i=0.
  - Expected: count_o=4, in_ready_o=0, 5th push ignored, out_pc_o=0x100, class=1, alu_op=0.
- Full queue, then assert in_valid_i and out_ready_i together.
  - Expected: pop only; count_o=3 next cycle, in_ready_o=1, head pc=0x104.
- Head MULT (0x00220018) with mdu_busy_i=1 for 3 cycles, out_ready_i=1.
  - Expected: out_valid_o=0 for those 3 cycles, mdu_op=4, class=3; pops the cycle after busy drops.
- 3 entries queued, flush_i=1 with simultaneous in_valid_i (pc 0x200).
  - Expected: next cycle count_o=0, out_valid_o=0; pc 0x200 never appears.
- Push 0xFC000000 (reserved opcode), then LUI 0x3C01ABCD, then SW 0xAC220004.
  - Expected in order:
    - rsvd=1, class=0;
    - class=1, alu_op=10, regwr=1;
    - class=5, regwr=0.
- DEPTH=3 build with 10 push/pop interleavings.
  - Expected: pointer wrap 2 to 0 preserves FIFO order, and count_o matches a scoreboard every cycle.
